// File: rtl/ucsbece154b_result_checker_if.sv
// Handshake/result bundle between a test harness and the end-of-run result checker.
// The optional trigger wire exists only when RESULT_CHECKER_TRIGGER_EN is defined.
interface ucsbece154b_result_checker_if #(
    parameter int NUM_CHECKS  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int CYCLE_WIDTH = 16
);
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int CNT_W = $clog2(NUM_CHECKS + 1);

    logic                             start;
    logic [NUM_CHECKS*DATA_WIDTH-1:0] probe_data;
    logic [NUM_CHECKS*DATA_WIDTH-1:0] expect_data;
    logic [NUM_CHECKS-1:0]            check_en;
`ifdef RESULT_CHECKER_TRIGGER_EN
    logic                             trigger;
`endif
    logic                             busy;
    logic                             done;
    logic                             pass;
    logic [CNT_W-1:0]                 fail_count;
    logic [IDX_W-1:0]                 first_fail_idx;
    logic [CYCLE_WIDTH-1:0]           cycle_count;

    modport master (
        output start, probe_data, expect_data, check_en,
`ifdef RESULT_CHECKER_TRIGGER_EN
        output trigger,
`endif
        input  busy, done, pass, fail_count, first_fail_idx, cycle_count
    );

    modport slave (
        input  start, probe_data, expect_data, check_en,
`ifdef RESULT_CHECKER_TRIGGER_EN
        input  trigger,
`endif
        output busy, done, pass, fail_count, first_fail_idx, cycle_count
    );
endinterface

// File: rtl/ucsbece154b_result_checker.sv
// End-of-run result checker: runs the core for a cycle budget, then compares probe/expect
// channels one per cycle. Define RESULT_CHECKER_TRIGGER_EN to allow an early-exit trigger.
module ucsbece154b_result_checker #(
    parameter int NUM_CHECKS  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int CYCLE_WIDTH = 16,
    parameter int RUN_CYCLES  = 100
) (
    input logic clk,
    input logic reset,
    ucsbece154b_result_checker_if.slave bus
);
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int CNT_W = $clog2(NUM_CHECKS + 1);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CYCLE_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]       fail_count_q, fail_count_d;
    logic [IDX_W-1:0]       first_fail_idx_q, first_fail_idx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [DATA_WIDTH-1:0]  probe_sel;
    logic [DATA_WIDTH-1:0]  expect_sel;
    logic                   mismatch;
    logic                   trig;

    // Single shared comparator, steered by the channel index.
    assign probe_sel  = bus.probe_data[idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign expect_sel = bus.expect_data[idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign mismatch   = bus.check_en[idx_q] && (probe_sel != expect_sel);

    always_comb begin
        trig = 1'b0;
`ifdef RESULT_CHECKER_TRIGGER_EN
        trig = bus.trigger;
`endif
    end

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        cycle_count_d    = cycle_count_q;
        fail_count_d     = fail_count_q;
        first_fail_idx_d = first_fail_idx_q;
        busy_d           = busy_q;
        done_d           = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d          = RUN;
                    idx_d            = '0;
                    cycle_count_d    = '0;
                    fail_count_d     = '0;
                    first_fail_idx_d = '0;
                    busy_d           = 1'b1;
                    done_d           = 1'b0;
                end
            end
            RUN: begin
                // A trigger edge is not counted, so cycle_count reports cycles actually run.
                if (trig) begin
                    state_d = CHECK;
                    idx_d   = '0;
                end else begin
                    cycle_count_d = cycle_count_q + CYCLE_WIDTH'(1);
                    if (cycle_count_q == CYCLE_WIDTH'(RUN_CYCLES - 1)) begin
                        state_d = CHECK;
                        idx_d   = '0;
                    end
                end
            end
            CHECK: begin
                if (mismatch) begin
                    fail_count_d = fail_count_q + CNT_W'(1);
                    if (fail_count_q == '0) first_fail_idx_d = idx_q;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_CHECKS - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            cycle_count_q    <= '0;
            fail_count_q     <= '0;
            first_fail_idx_q <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            cycle_count_q    <= cycle_count_d;
            fail_count_q     <= fail_count_d;
            first_fail_idx_q <= first_fail_idx_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = (state_q == DONE) && (fail_count_q == '0);
    assign bus.fail_count     = fail_count_q;
    assign bus.first_fail_idx = first_fail_idx_q;
    assign bus.cycle_count    = cycle_count_q;
endmodule

// File: tb/tb_ucsbece154b_result_checker.sv
// Directed bench for the result checker with NUM_CHECKS=4, RUN_CYCLES=8, DATA_WIDTH=32.
// Define RESULT_CHECKER_TRIGGER_EN to also exercise the early-exit trigger.
module tb_ucsbece154b_result_checker;
    localparam int NC = 4;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int RC = 8;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    ucsbece154b_result_checker_if #(.NUM_CHECKS(NC), .DATA_WIDTH(DW), .CYCLE_WIDTH(CW)) bus ();

    ucsbece154b_result_checker #(
        .NUM_CHECKS(NC), .DATA_WIDTH(DW), .CYCLE_WIDTH(CW), .RUN_CYCLES(RC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic set_probes(input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3);
        bus.probe_data = {p3, p2, p1, p0};
    endtask

    task automatic chk_done(input string tag, input logic ps, input int fc, input int ffi,
                            input int cc);
        chk({tag, "_done"}, bus.done, 1'b1);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_pass"}, bus.pass, ps);
        chk({tag, "_fail_count"}, bus.fail_count, fc);
        chk({tag, "_first_fail"}, bus.first_fail_idx, ffi);
        chk({tag, "_cycle_count"}, bus.cycle_count, cc);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.check_en = 4'b1111;
        bus.expect_data = {4{32'h19}};
        set_probes(32'h19, 32'h19, 32'h19, 32'h19);
`ifdef RESULT_CHECKER_TRIGGER_EN
        bus.trigger = 1'b0;
`endif
        step(2);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_pass", bus.pass, 1'b0);
        chk("rst_fail_count", bus.fail_count, 0);
        chk("rst_first_fail", bus.first_fail_idx, 0);
        chk("rst_cycle_count", bus.cycle_count, 0);
        reset = 1'b0;
        step(3);
        chk("idle_stays_busy", bus.busy, 1'b0);

        // Scenario 1: all channels match.
        pulse_start();                       // E0
        chk("s1_busy_e0", bus.busy, 1'b1);
        chk("s1_done_e0", bus.done, 1'b0);
        step(4);                             // E4
        chk("s1_cycle_e4", bus.cycle_count, 4);
        step(7);                             // E11
        chk("s1_done_e11", bus.done, 1'b0);
        chk("s1_busy_e11", bus.busy, 1'b1);
        step(1);                             // E12
        chk_done("s1", 1'b1, 0, 0, 8);
        step(5);
        chk("s1_hold_done", bus.done, 1'b1);
        chk("s1_hold_cycle", bus.cycle_count, 8);

        // Scenario 2: channels 1 and 3 mismatch; restart straight from DONE.
        set_probes(32'h19, 32'h7, 32'h19, 32'h7);
        pulse_start();
        chk("s2_done_drops", bus.done, 1'b0);
        chk("s2_busy_rises", bus.busy, 1'b1);
        chk("s2_pass_drops", bus.pass, 1'b0);
        chk("s2_cleared_fc", bus.fail_count, 0);
        step(12);
        chk_done("s2", 1'b0, 2, 1, 8);

        // Scenario 3: masked mismatch on channel 2.
        set_probes(32'h19, 32'h19, 32'h7, 32'h19);
        bus.check_en = 4'b1011;
        pulse_start();
        step(12);
        chk_done("s3", 1'b1, 0, 0, 8);

        // Scenario 3b: unmasked, a single late mismatch on channel 2.
        bus.check_en = 4'b1111;
        pulse_start();
        step(12);
        chk_done("s3b", 1'b0, 1, 2, 8);

        // Scenario 4: reset on the edge evaluating channel 2 of a failing run.
        set_probes(32'h19, 32'h7, 32'h19, 32'h7);
        pulse_start();                       // E0
        step(10);                            // E10: channel 1 evaluated
        chk("s4_mid_fc", bus.fail_count, 1);
        chk("s4_mid_busy", bus.busy, 1'b1);
        reset = 1'b1;
        step(1);                             // E11
        reset = 1'b0;
        chk("s4_busy", bus.busy, 1'b0);
        chk("s4_done", bus.done, 1'b0);
        chk("s4_fc", bus.fail_count, 0);
        chk("s4_first_fail", bus.first_fail_idx, 0);
        chk("s4_cycle", bus.cycle_count, 0);
        set_probes(32'h19, 32'h19, 32'h19, 32'h19);
        pulse_start();
        chk("s4_restart_busy", bus.busy, 1'b1);
        step(11);
        chk("s4_restart_e11", bus.done, 1'b0);
        step(1);
        chk_done("s4r", 1'b1, 0, 0, 8);

        // Scenario 5: start during RUN and CHECK is ignored.
        set_probes(32'h7, 32'h19, 32'h19, 32'h19);
        pulse_start();                       // E0
        step(2);                             // E2
        pulse_start();                       // E3 (RUN)
        chk("s5_run_cycle", bus.cycle_count, 3);
        step(6);                             // E9
        pulse_start();                       // E10 (CHECK)
        step(1);                             // E11
        chk("s5_done_e11", bus.done, 1'b0);
        step(1);                             // E12
        chk_done("s5", 1'b0, 1, 0, 8);

`ifdef RESULT_CHECKER_TRIGGER_EN
        // Scenario 6: trigger at E4 ends RUN early.
        set_probes(32'h19, 32'h19, 32'h19, 32'h19);
        pulse_start();                       // E0
        step(3);                             // E3
        chk("s6_cycle_e3", bus.cycle_count, 3);
        bus.trigger = 1'b1;
        step(1);                             // E4
        bus.trigger = 1'b0;
        chk("s6_cycle_e4", bus.cycle_count, 3);
        chk("s6_busy_e4", bus.busy, 1'b1);
        step(3);                             // E7
        chk("s6_done_e7", bus.done, 1'b0);
        step(1);                             // E8
        chk_done("s6", 1'b1, 0, 0, 3);
        bus.trigger = 1'b1;
        step(2);
        bus.trigger = 1'b0;
        chk("s6_trig_in_done", bus.done, 1'b1);
        pulse_start();
        step(12);
        chk_done("s6_notrig", 1'b1, 0, 0, 8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ucsbece154b_result_checker.md
Name: ucsbece154b_result_checker

Overview:
Parametrised end-of-run result checker for the pipelined RISC-V top.
- After a start pulse it lets the core run for a fixed cycle budget.
- It then walks NUM_CHECKS probe/expect channel pairs, one per cycle, through a single shared comparator.
- It reports pass/fail, mismatch count and first failing channel.
- Probes are typically wired to register-file and data-memory words; the block replaces per-test hardcoded delay-and-compare sequences.

Parameters:
- NUM_CHECKS, 16, number of probe/expect channel pairs (>=1)
- DATA_WIDTH, 32, width of each probe/expect word
- CYCLE_WIDTH, 16, width of the run-cycle counter; must hold RUN_CYCLES
- RUN_CYCLES, 100, cycles the core runs before checking begins (>=1)
- IDX_W, derived = max(1, clog2(NUM_CHECKS)), channel index width
- CNT_W, derived = clog2(NUM_CHECKS+1), mismatch count width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; all state cleared
- start  in  1  begin a run; honoured in IDLE and DONE only
- probe_data  in  NUM_CHECKS*DATA_WIDTH  observed values; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- expect_data  in  NUM_CHECKS*DATA_WIDTH  golden values, same packing
- check_en  in  NUM_CHECKS  per-channel enable; 0 = channel ignored
- busy  out  1  high in RUN or CHECK
- done  out  1  high in DONE
- pass  out  1  high in DONE when fail_count==0
- fail_count  out  CNT_W  number of enabled mismatching channels
- first_fail_idx  out  IDX_W  lowest mismatching channel index; 0 when none
- cycle_count  out  CYCLE_WIDTH  run cycles consumed

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- States: IDLE, RUN, CHECK, DONE.
- Reset values: all outputs 0, state IDLE, internal index 0. Reset wins over every other input in every state, including mid-RUN and mid-CHECK.
- IDLE:
  - start=1: next state RUN; cycle_count, fail_count and first_fail_idx cleared.
- RUN:
  - cycle_count increments each edge.
  - On the edge where cycle_count==RUN_CYCLES-1, go to CHECK with index 0; cycle_count then holds RUN_CYCLES.
  - RUN therefore lasts exactly RUN_CYCLES cycles.
- CHECK:
  - Each cycle, evaluate channel idx: mismatch = check_en[idx] && probe!=expect.
  - On mismatch, fail_count increments. If fail_count was 0, first_fail_idx <= idx.
  - idx increments; on the edge where idx==NUM_CHECKS-1 is evaluated, go to DONE.
  - CHECK lasts exactly NUM_CHECKS cycles.
- Sampling: probe and expect are sampled at the cycle their channel is evaluated. The core must be quiescent (halt loop) by then.
- Latency: start sampled at edge E0 gives done=1 after edge E0+RUN_CYCLES+NUM_CHECKS. busy=1 from after E0 until DONE.
- DONE:
  - Outputs hold indefinitely.
  - start=1 restarts into RUN with counters cleared; done drops on the next edge.
- start is ignored in RUN and CHECK.
- fail_count cannot overflow, since CNT_W holds NUM_CHECKS.
- cycle_count never wraps under the CYCLE_WIDTH constraint.
- pass is combinational from state and fail_count; all other outputs are registered.

Optional Feature:
Macro RESULT_CHECKER_TRIGGER_EN.
- Defined:
  - Adds input port trigger (1 bit), e.g. halt/ebreak detect from the core.
  - trigger=1 sampled in RUN moves to CHECK on that edge regardless of the counter.
  - cycle_count does not increment on the trigger edge, so it reports the run cycles actually consumed.
  - trigger is ignored outside RUN.
  - If trigger and the final counter edge coincide, the behaviour is the same transition, with cycle_count = RUN_CYCLES-1.
- Undefined: port absent; RUN always lasts RUN_CYCLES cycles.

Test Plan:
Configuration: NUM_CHECKS=4, RUN_CYCLES=8, DATA_WIDTH=32; start pulsed at edge E0.
1. All channels match, check_en=4'b1111 -> busy after E0; done=1 and pass=1 after E12; fail_count=0, first_fail_idx=0, cycle_count=8.
2. Channels 1 and 3 mismatch (probe 32'h7 vs expect 32'h19) -> after E12: pass=0, fail_count=2, first_fail_idx=1.
3. Channel 2 mismatches with check_en=4'b1011 -> pass=1, fail_count=0.
4. reset=1 at the edge evaluating channel 2 of a failing run -> next cycle: busy=0, done=0, fail_count=0, cycle_count=0. A fresh start then completes per scenario 1 timing.
5. start pulsed during RUN and CHECK -> no effect, done still after E12. start in DONE -> done=0 after next edge, new run completes 12 edges later.
6. With RESULT_CHECKER_TRIGGER_EN, trigger=1 at E4 (cycle_count=3) -> CHECK from E4, cycle_count stays 3, done after E8; no-trigger run still finishes after E12.
